// File: rtl/frame_sched_ctrl_pkg.sv
// Shared definitions for the frame scheduler and the byte serializer it drives.
// State encoding, default framing bytes and the default channel count.
package frame_sched_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KICK = 3'd1,
        ST_HDR  = 3'd2,
        ST_DATA = 3'd3,
        ST_FTR  = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    localparam int         NUM_CHANNELS_DEF = 16;
    localparam logic [7:0] HEADER_BYTE      = 8'hAA;
    localparam logic [7:0] FOOTER_BYTE      = 8'hFF;

endpackage

// File: rtl/frame_sched_ctrl_if.sv
// Channel-write, trigger and serializer-feed signals of the frame scheduler.
// The master side drives writes and triggers; the slave side is the scheduler.
interface frame_sched_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              ch_wr_en;
    logic [ADDR_W-1:0] ch_wr_addr;
    logic [7:0]        ch_wr_data;
    logic              trigger;
    logic [7:0]        ser_din;
    logic              ser_din_valid;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic [CNT_W-1:0]  frame_count;

    modport master (
        output ch_wr_en, ch_wr_addr, ch_wr_data, trigger,
        input  ser_din, ser_din_valid, busy, frame_done, overrun, frame_count
    );

    modport slave (
        input  ch_wr_en, ch_wr_addr, ch_wr_data, trigger,
        output ser_din, ser_din_valid, busy, frame_done, overrun, frame_count
    );
endinterface

// File: rtl/frame_sched_ctrl_chan_bank.sv
// Per-channel register bank with a frame snapshot and a read mux on the snapshot.
// A write coinciding with a snapshot lands in the snapshot too (write-through).
module frame_sched_ctrl_chan_bank
    import frame_sched_ctrl_pkg::*;
#(
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_snap,
    input  logic [ADDR_W-1:0] i_rd_idx,
    output logic [7:0]        o_rd_data
);
    logic [7:0] r_bank [NUM_CHANNELS];
    logic [7:0] r_snap [NUM_CHANNELS];

    // Addresses at or beyond NUM_CHANNELS never match any entry and are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_bank[i] <= 8'h00;
                r_snap[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (i_wr_en && (i_wr_addr == ADDR_W'(i)))
                    r_bank[i] <= i_wr_data;
                if (i_snap)
                    r_snap[i] <= (i_wr_en && (i_wr_addr == ADDR_W'(i))) ? i_wr_data : r_bank[i];
            end
        end
    end

    always_comb begin
        o_rd_data = 8'h00;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (i_rd_idx == ADDR_W'(i))
                o_rd_data = r_snap[i];
        end
    end
endmodule

// File: rtl/frame_sched_ctrl.sv
// Frame scheduler: streams a bank snapshot into the byte serializer as KICK, HDR,
// NUM_CHANNELS data bytes and FTR, with one-deep trigger queueing and an optional gap.
module frame_sched_ctrl
    import frame_sched_ctrl_pkg::*;
#(
    parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
    parameter int ADDR_W       = 4,
    parameter int GAP_CYCLES   = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    frame_sched_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CHANNELS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [7:0]        r_gap_cnt;
    logic              r_pending;
    logic              r_overrun;
    logic [CNT_W-1:0]  r_frame_count;
    logic              w_snap;
    logic              w_again;
    logic [7:0]        w_rd_data;

    frame_sched_ctrl_chan_bank #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .ADDR_W       (ADDR_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (bus.ch_wr_en),
        .i_wr_addr (bus.ch_wr_addr),
        .i_wr_data (bus.ch_wr_data),
        .i_snap    (w_snap),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_rd_data)
    );

    // A trigger arriving on the frame's last cycle chains straight into the next KICK.
    assign w_again = r_pending | bus.trigger;

    always_comb begin
        w_next = r_state;
        w_snap = 1'b0;
        unique case (r_state)
            ST_IDLE: if (bus.trigger) begin
                w_next = ST_KICK;
                w_snap = 1'b1;
            end
            ST_KICK: w_next = ST_HDR;
            ST_HDR:  w_next = ST_DATA;
            ST_DATA: if (r_idx == LAST_IDX) w_next = ST_FTR;
            ST_FTR: begin
                if (GAP_CYCLES > 0) begin
                    w_next = ST_GAP;
                end else if (w_again) begin
                    w_next = ST_KICK;
                    w_snap = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_GAP: if (r_gap_cnt == 8'd0) begin
                if (w_again) begin
                    w_next = ST_KICK;
                    w_snap = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_gap_cnt     <= 8'd0;
            r_pending     <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state   <= w_next;
            r_overrun <= 1'b0;
            if (r_state == ST_DATA)
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + ADDR_W'(1);
            if (r_state == ST_FTR) begin
                r_frame_count <= r_frame_count + CNT_W'(1);
                r_gap_cnt     <= 8'(GAP_CYCLES - 1);
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
            // Consuming the pending slot with a coincident trigger re-arms it.
            if (r_state != ST_IDLE) begin
                if (w_snap)
                    r_pending <= r_pending & bus.trigger;
                else if (bus.trigger) begin
                    if (r_pending) r_overrun <= 1'b1;
                    else           r_pending <= 1'b1;
                end
            end
        end
    end

    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.ser_din_valid = (r_state == ST_KICK) || (r_state == ST_DATA);
    assign bus.ser_din       = (r_state == ST_DATA) ? w_rd_data : 8'h00;
    assign bus.frame_done    = (r_state == ST_FTR);
    assign bus.overrun       = r_overrun;
    assign bus.frame_count   = r_frame_count;
endmodule

// File: tb/tb_frame_sched_ctrl.sv
// Directed bench for frame_sched_ctrl: a vector table for back-to-back frames with
// queued/dropped triggers, plus sequences for reset, write-through, gap and range.
module tb_frame_sched_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    frame_sched_ctrl_if #(.ADDR_W(4), .CNT_W(16)) bus0 ();
    frame_sched_ctrl_if #(.ADDR_W(4), .CNT_W(16)) bus1 ();
    frame_sched_ctrl_if #(.ADDR_W(4), .CNT_W(16)) bus2 ();

    frame_sched_ctrl #(.NUM_CHANNELS(16), .ADDR_W(4), .GAP_CYCLES(0), .CNT_W(16))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    frame_sched_ctrl #(.NUM_CHANNELS(16), .ADDR_W(4), .GAP_CYCLES(3), .CNT_W(16))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    frame_sched_ctrl #(.NUM_CHANNELS(12), .ADDR_W(4), .GAP_CYCLES(0), .CNT_W(16))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic        trig;
        logic        wr_en;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic        e_valid;
        logic [7:0]  e_din;
        logic        e_busy;
        logic        e_done;
        logic        e_ovr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[40];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input int step, input logic v, input logic [7:0] d,
                        input logic b, input logic fd, input logic ov, input logic [15:0] c);
        chk({tag, ".valid"}, step, bus0.ser_din_valid, v);
        chk({tag, ".din"},   step, bus0.ser_din, d);
        chk({tag, ".busy"},  step, bus0.busy, b);
        chk({tag, ".done"},  step, bus0.frame_done, fd);
        chk({tag, ".ovr"},   step, bus0.overrun, ov);
        chk({tag, ".cnt"},   step, bus0.frame_count, c);
    endtask

    task automatic wr0(input logic [3:0] a, input logic [7:0] d);
        bus0.ch_wr_en = 1'b1; bus0.ch_wr_addr = a; bus0.ch_wr_data = d;
        tick();
        bus0.ch_wr_en = 1'b0;
    endtask

    initial begin
        bus0.ch_wr_en = 0; bus0.ch_wr_addr = 0; bus0.ch_wr_data = 0; bus0.trigger = 0;
        bus1.ch_wr_en = 0; bus1.ch_wr_addr = 0; bus1.ch_wr_data = 0; bus1.trigger = 0;
        bus2.ch_wr_en = 0; bus2.ch_wr_addr = 0; bus2.ch_wr_data = 0; bus2.trigger = 0;

        // Two frames: triggers at 0 (start), 4 (queued), 8 (dropped); bank[5] rewritten mid-frame.
        for (int s = 0; s < 40; s++) begin
            vecs[s] = '{trig: 0, wr_en: 0, addr: 0, data: 0, e_valid: 0, e_din: 0,
                        e_busy: (s < 38), e_done: 0, e_ovr: 0, e_cnt: 0};
            if (s == 0 || s == 19) vecs[s].e_valid = 1'b1;
            if (s >= 2 && s <= 17) begin
                vecs[s].e_valid = 1'b1;
                vecs[s].e_din   = 8'h10 + 8'(s - 2);
            end
            if (s >= 21 && s <= 36) begin
                vecs[s].e_valid = 1'b1;
                vecs[s].e_din   = (s == 26) ? 8'h55 : 8'h10 + 8'(s - 21);
            end
            if (s == 18 || s == 37) vecs[s].e_done = 1'b1;
            if (s == 0 || s == 4 || s == 8) vecs[s].trig = 1'b1;
            if (s == 8) vecs[s].e_ovr = 1'b1;
            if (s == 6) begin
                vecs[s].wr_en = 1'b1; vecs[s].addr = 4'd5; vecs[s].data = 8'h55;
            end
            vecs[s].e_cnt = (s < 19) ? 16'd0 : (s < 38) ? 16'd1 : 16'd2;
        end

        tick(); tick();
        chk0("reset", 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) wr0(4'(i), 8'h10 + 8'(i));
        chk0("idle", 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);

        for (int s = 0; s < 40; s++) begin
            bus0.trigger    = vecs[s].trig;
            bus0.ch_wr_en   = vecs[s].wr_en;
            bus0.ch_wr_addr = vecs[s].addr;
            bus0.ch_wr_data = vecs[s].data;
            tick();
            chk0("vec", s, vecs[s].e_valid, vecs[s].e_din, vecs[s].e_busy,
                 vecs[s].e_done, vecs[s].e_ovr, vecs[s].e_cnt);
        end
        bus0.trigger = 0; bus0.ch_wr_en = 0;

        // Reset in the middle of DATA aborts the frame and clears everything.
        bus0.trigger = 1'b1; tick(); bus0.trigger = 1'b0;
        for (int s = 1; s < 9; s++) tick();
        chk("rst.pre_valid", 9, bus0.ser_din_valid, 1'b1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk0("rst", 10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int s = 11; s < 31; s++) begin
            tick();
            chk("rst.no_done", s, bus0.frame_done, 1'b0);
            chk("rst.idle", s, bus0.busy, 1'b0);
        end

        // Fresh frame after reset: bank was cleared, only 0 and 15 rewritten.
        wr0(4'd0, 8'h5A);
        wr0(4'd15, 8'hA5);
        bus0.trigger = 1'b1; tick(); bus0.trigger = 1'b0;
        chk("post.kick", 0, bus0.ser_din_valid, 1'b1);
        for (int s = 1; s < 20; s++) begin
            tick();
            if (s >= 2 && s <= 17)
                chk("post.din", s, bus0.ser_din, (s == 2) ? 8'h5A : (s == 17) ? 8'hA5 : 8'h00);
            if (s == 18) chk("post.done", s, bus0.frame_done, 1'b1);
        end
        chk("post.cnt", 19, bus0.frame_count, 16'd1);
        chk("post.idle", 19, bus0.busy, 1'b0);

        // Write to slot 15 in the trigger cycle must reach the snapshot.
        bus0.ch_wr_en = 1'b1; bus0.ch_wr_addr = 4'd15; bus0.ch_wr_data = 8'hC3;
        bus0.trigger = 1'b1;
        tick();
        bus0.ch_wr_en = 1'b0; bus0.trigger = 1'b0;
        for (int s = 1; s < 20; s++) begin
            tick();
            if (s == 2)  chk("wt.slot0", s, bus0.ser_din, 8'h5A);
            if (s == 17) chk("wt.slot15", s, bus0.ser_din, 8'hC3);
        end
        chk("wt.cnt", 19, bus0.frame_count, 16'd2);

        // GAP_CYCLES=3 with trigger held: period 22, three idle gap cycles after FTR.
        bus1.trigger = 1'b1;
        for (int s = 0; s < 50; s++) begin
            int ph;
            tick();
            ph = s % 22;
            chk("gap.valid", s, bus1.ser_din_valid, (ph == 0) || (ph >= 2 && ph <= 17));
            chk("gap.done", s, bus1.frame_done, ph == 18);
            chk("gap.busy", s, bus1.busy, 1'b1);
        end
        chk("gap.cnt", 50, bus1.frame_count, 16'd2);
        bus1.trigger = 1'b0;

        // 12-channel instance: addresses 12 and 13 are out of range and must be ignored.
        for (int i = 0; i < 12; i++) begin
            bus2.ch_wr_en = 1'b1; bus2.ch_wr_addr = 4'(i); bus2.ch_wr_data = 8'h20 + 8'(i);
            tick();
        end
        bus2.ch_wr_addr = 4'd13; bus2.ch_wr_data = 8'hEE; tick();
        bus2.ch_wr_addr = 4'd12; bus2.ch_wr_data = 8'hDD; tick();
        bus2.ch_wr_en = 1'b0;
        bus2.trigger = 1'b1; tick(); bus2.trigger = 1'b0;
        chk("n12.kick", 0, bus2.ser_din_valid, 1'b1);
        for (int s = 1; s < 16; s++) begin
            tick();
            if (s >= 2 && s <= 13) chk("n12.din", s, bus2.ser_din, 8'h20 + 8'(s - 2));
            if (s == 14) chk("n12.done", s, bus2.frame_done, 1'b1);
        end
        chk("n12.idle", 15, bus2.busy, 1'b0);
        chk("n12.cnt", 15, bus2.frame_count, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
